// File: rtl/cla_pkg.sv
// Shared definitions for the pipelined carry-lookahead adder/subtractor.
package cla_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic int ngroups(input int width, input int group);
    return width / group;
  endfunction

  function automatic bit params_ok(input int width, input int group);
    return (group >= 1) && (width >= group) && ((width % group) == 0);
  endfunction

endpackage

// File: rtl/cla_group.sv
// Combinational GROUP-bit carry-lookahead slice; every carry is a flat
// sum of generate/propagate products rather than a ripple chain.
module cla_group #(
  parameter int GROUP = 4
) (
  input  logic [GROUP-1:0] x,
  input  logic [GROUP-1:0] y,
  input  logic             ci,
  output logic [GROUP-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [GROUP-1:0] p;
  logic [GROUP-1:0] g;
  logic [GROUP:0]   c;

  assign p = x ^ y;
  assign g = x & y;

  always_comb begin
    logic term;
    term = 1'b0;
    c    = '0;
    c[0] = ci;
    for (int i = 0; i < GROUP; i++) begin
      term = ci;
      for (int j = 0; j <= i; j++) term = term & p[j];
      c[i+1] = term;
      for (int j = 0; j <= i; j++) begin
        term = g[j];
        for (int m = j + 1; m <= i; m++) term = term & p[m];
        c[i+1] = c[i+1] | term;
      end
    end
  end

  assign s        = p ^ c[GROUP-1:0];
  assign co       = c[GROUP];
  assign c_msb_in = c[GROUP-1];

endmodule

// File: rtl/cla_addsub_pipe.sv
// Pipelined add/subtract: one CLA group per register stage, the group carry
// ripples stage to stage, and the whole pipe stalls on output backpressure.
module cla_addsub_pipe
  import cla_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int GROUP = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int NG = ngroups(WIDTH, GROUP);

  if (!params_ok(WIDTH, GROUP)) begin : g_bad_params
    $error("cla_addsub_pipe: WIDTH must be a positive multiple of GROUP");
  end

  logic             advance;
  logic [WIDTH-1:0] b_eff;
  logic             ov_q;
  logic             zero_q;
  logic             neg_q;

  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;
  assign b_eff    = (mode == MODE_SUB) ? ~b : b;

  for (genvar k = 0; k < NG; k++) begin : g_stg
    // WK: operand bits not yet consumed entering this stage; WR: result bits done after it
    localparam int WK = WIDTH - k * GROUP;
    localparam int WR = (k + 1) * GROUP;

    logic [WK-1:0]    x_i;
    logic [WK-1:0]    y_i;
    logic             ci_i;
    logic             v_i;
    logic [GROUP-1:0] s;
    logic             co;
    logic             cm;
    logic [WR-1:0]    r_n;
    logic [WR-1:0]    r_q;
    logic             c_q;
    logic             v_q;

    if (k == 0) begin : g_first
      assign x_i  = a;
      assign y_i  = b_eff;
      assign ci_i = cin ^ mode;
      assign v_i  = in_valid;
      assign r_n  = s;
    end else begin : g_next
      assign x_i  = g_stg[k-1].g_fwd.a_q;
      assign y_i  = g_stg[k-1].g_fwd.b_q;
      assign ci_i = g_stg[k-1].c_q;
      assign v_i  = g_stg[k-1].v_q;
      assign r_n  = {s, g_stg[k-1].r_q};
    end

    cla_group #(.GROUP(GROUP)) u_grp (
      .x        (x_i[GROUP-1:0]),
      .y        (y_i[GROUP-1:0]),
      .ci       (ci_i),
      .s        (s),
      .co       (co),
      .c_msb_in (cm)
    );

    always_ff @(posedge clk) begin
      if (rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (advance) begin
        v_q <= v_i;
        c_q <= co;
        r_q <= r_n;
      end
    end

    if (k < NG - 1) begin : g_fwd
      logic [WK-GROUP-1:0] a_q;
      logic [WK-GROUP-1:0] b_q;

      always_ff @(posedge clk) begin
        if (rst) begin
          a_q <= '0;
          b_q <= '0;
        end else if (advance) begin
          a_q <= x_i[WK-1:GROUP];
          b_q <= y_i[WK-1:GROUP];
        end
      end
    end else begin : g_last
      // Flags are registered alongside res so they carry no extra latency.
      always_ff @(posedge clk) begin
        if (rst) begin
          ov_q   <= 1'b0;
          zero_q <= 1'b0;
          neg_q  <= 1'b0;
        end else if (advance) begin
          ov_q   <= co ^ cm;
          zero_q <= (r_n == '0);
          neg_q  <= r_n[WR-1];
        end
      end
    end
  end

  assign out_valid = g_stg[NG-1].v_q;
  assign res       = g_stg[NG-1].r_q;
  assign carry     = g_stg[NG-1].c_q;
  assign overflow  = ov_q;
  assign zero      = zero_q;
  assign negative  = neg_q;

endmodule
